sram_mem_controller: RTL and testbench

- Multi-cycle controller between the pipeline MEM stage and an external 16-bit asynchronous SRAM. It replaces the single-cycle data memory.
- Each 32-bit word load or store is sequenced as two half-word SRAM accesses: low half first, then high half.
- While an access is in flight, `ready` is held low. Pipeline control uses ~ready to freeze all stage registers.

---
 rtl/sram_mem_controller.sv | 202 ++++++++++++++++++++
 tb/tb_sram_mem_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// Multi-cycle 32-bit MEM-stage controller for a 16-bit asynchronous SRAM (low half, then high half).
// Optional macro SRAM_ACCESS_COUNT_EN adds read_count/write_count outputs.
//
// state | meaning
// IDLE  | no access pending; accepts rd_en/wr_en
// LO    | low half-word phase, WAIT_CYCLES+1 cycles
// HI    | high half-word phase, WAIT_CYCLES+1 cycles
// DONE  | one-cycle completion, ready high, strobes idle
module sram_mem_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter int          ADDR_W      = 18,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    output logic              sram_oe_n
`ifdef SRAM_ACCESS_COUNT_EN
    ,
    output logic [15:0]       read_count,
    output logic [15:0]       write_count
`endif
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-2:0]  word_q, word_d;
    logic [31:0]        data_q, data_d;
    logic               is_wr_q, is_wr_d;
    logic [15:0]        shadow_lo_q, shadow_lo_d;
    logic [31:0]        read_data_q, read_data_d;
    logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;
`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0]        read_count_q, read_count_d;
    logic [15:0]        write_count_q, write_count_d;
`endif

    logic              req;
    logic              phase_end;
    logic [ADDR_W-2:0] req_word;

    assign req       = rd_en | wr_en;
    assign phase_end = (cnt_q == CNT_MAX);
    // Byte offset from the SRAM window, divided down to a 32-bit word index and truncated.
    assign req_word  = (ADDR_W-1)'((address - BASE_ADDR) >> 2);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        data_d      = data_q;
        is_wr_d     = is_wr_q;
        shadow_lo_d = shadow_lo_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        we_n_d      = we_n_q;
        oe_n_d      = oe_n_q;
`ifdef SRAM_ACCESS_COUNT_EN
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d     = S_LO;
                    cnt_d       = '0;
                    word_d      = req_word;
                    data_d      = write_data;
                    is_wr_d     = wr_en;
                    sram_addr_d = {req_word, 1'b0};
                    dq_out_d    = wr_en ? write_data[15:0] : 16'h0000;
                    dq_oe_d     = wr_en;
                    we_n_d      = ~wr_en;
                    oe_n_d      = wr_en;
                end
            end
            S_LO: begin
                if (phase_end) begin
                    state_d     = S_HI;
                    cnt_d       = '0;
                    sram_addr_d = {word_q, 1'b1};
                    if (is_wr_q) begin
                        dq_out_d = data_q[31:16];
                    end else begin
                        shadow_lo_d = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HI: begin
                if (phase_end) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    dq_oe_d = 1'b0;
                    we_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    if (!is_wr_q) begin
                        read_data_d = {sram_dq_in, shadow_lo_q};
                    end
`ifdef SRAM_ACCESS_COUNT_EN
                    if (is_wr_q) begin
                        write_count_d = write_count_q + 16'd1;
                    end else begin
                        read_count_d = read_count_q + 16'd1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Requests still high here belong to the instruction that is completing.
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            data_q      <= '0;
            is_wr_q     <= 1'b0;
            shadow_lo_q <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
`ifdef SRAM_ACCESS_COUNT_EN
            read_count_q  <= '0;
            write_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            data_q      <= data_d;
            is_wr_q     <= is_wr_d;
            shadow_lo_q <= shadow_lo_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
`ifdef SRAM_ACCESS_COUNT_EN
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
`endif
        end
    end

    // ready drops in the same cycle a request is seen so the pipeline freezes immediately.
    assign ready = !rst ? 1'b1 :
                   (state_q == S_IDLE) ? ~req :
                   (state_q == S_DONE);

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;
`ifdef SRAM_ACCESS_COUNT_EN
    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: directed vector table, multi-cycle corner sequences and
// randomized accesses checked against a word-level memory model.
module tb_sram_mem_controller;
    localparam int WAIT_CYCLES = 2;
    localparam int LAT         = 2 * WAIT_CYCLES + 3;
    localparam int PH_LAST     = 2 * WAIT_CYCLES + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;
`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0] read_count;
    logic [15:0] write_count;
    int          model_rcnt = 0;
    int          model_wcnt = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] sram_mem [0:4095] = '{default: 16'h0000};
    logic [31:0] model_mem [0:1023] = '{default: 32'h0};
    logic [31:0] model_rd = 32'h0;

    always #5 clk = ~clk;

    // Asynchronous SRAM: output data while OE is low, store on each clock while WE is low.
    assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr[11:0]];
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr[11:0]] <= sram_dq_out;
    end

    sram_mem_controller #(.WAIT_CYCLES(WAIT_CYCLES), .ADDR_W(18), .BASE_ADDR(1024)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .address(address),
        .write_data(write_data),
        .read_data(read_data),
        .ready(ready),
        .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe),
        .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n)
`ifdef SRAM_ACCESS_COUNT_EN
        ,
        .read_count(read_count),
        .write_count(write_count)
`endif
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          lo_idx;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } vec_t;

    vec_t vecs [0:5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one request and follows it cycle by cycle until ready returns (bounded).
    // Returns at the negedge of the completion cycle.
    task automatic run_access(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input bit hold,
                              output int lat, output int we_cnt, output int oe_cnt,
                              output int dqoe_cnt, output int first, output int last,
                              output logic done_idle);
        @(negedge clk);
        wr_en = w; rd_en = r; address = a; write_data = d;
        #1;
        lat = -1; we_cnt = 0; oe_cnt = 0; dqoe_cnt = 0; first = -1; last = -1; done_idle = 1'b0;
        check("ready_low_cycle0", {31'b0, ready}, 32'h0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!sram_we_n) begin we_cnt++; if (first < 0) first = c; last = c; end
            if (!sram_oe_n) begin oe_cnt++; if (first < 0) first = c; last = c; end
            if (sram_dq_oe) dqoe_cnt++;
            if (ready) begin
                lat = c;
                done_idle = sram_we_n & sram_oe_n & ~sram_dq_oe;
                break;
            end
            if (!hold) begin wr_en = 1'b0; rd_en = 1'b0; end
        end
    endtask

    // Issues an access and checks timing, strobes, read_data and SRAM contents against the model.
    task automatic access_and_check(input string tag, input logic w, input logic r,
                                    input logic [31:0] a, input logic [31:0] d, input bit hold);
        int lat, we_cnt, oe_cnt, dqoe_cnt, first, last;
        logic done_idle;
        int word;
        bit is_w;
        is_w = w;
        word = int'((a - 32'd1024) >> 2);
        run_access(w, r, a, d, hold, lat, we_cnt, oe_cnt, dqoe_cnt, first, last, done_idle);
        if (is_w) begin
            model_mem[word] = d;
`ifdef SRAM_ACCESS_COUNT_EN
            model_wcnt++;
`endif
        end else begin
            model_rd = model_mem[word];
`ifdef SRAM_ACCESS_COUNT_EN
            model_rcnt++;
`endif
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_strobe_first"}, first, 1);
        check({tag, "_strobe_last"}, last, PH_LAST);
        check({tag, "_we_cycles"}, we_cnt, is_w ? PH_LAST : 0);
        check({tag, "_oe_cycles"}, oe_cnt, is_w ? 0 : PH_LAST);
        check({tag, "_dqoe_cycles"}, dqoe_cnt, is_w ? PH_LAST : 0);
        check({tag, "_done_idle"}, {31'b0, done_idle}, 32'h1);
        check({tag, "_read_data"}, read_data, model_rd);
        check({tag, "_sram_lo"}, {16'h0, sram_mem[2*word]}, {16'h0, model_mem[word][15:0]});
        check({tag, "_sram_hi"}, {16'h0, sram_mem[2*word+1]}, {16'h0, model_mem[word][31:16]});
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h00000000, 0, 16'hBEEF, 16'hDEAD};
        vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 32'hDEADBEEF, 0, 16'hBEEF, 16'hDEAD};
        vecs[2] = '{1'b1, 1'b0, 32'd1036, 32'h12345678, 32'hDEADBEEF, 6, 16'h5678, 16'h1234};
        vecs[3] = '{1'b0, 1'b1, 32'd1038, 32'h00000000, 32'h12345678, 6, 16'h5678, 16'h1234};
        vecs[4] = '{1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 32'h12345678, 2, 16'hF00D, 16'hCAFE};
        vecs[5] = '{1'b0, 1'b1, 32'd1029, 32'h00000000, 32'hCAFEF00D, 2, 16'hF00D, 16'hCAFE};

        // Reset state
        #12;
        check("rst_ready", {31'b0, ready}, 32'h1);
        check("rst_we_n", {31'b0, sram_we_n}, 32'h1);
        check("rst_oe_n", {31'b0, sram_oe_n}, 32'h1);
        check("rst_dq_oe", {31'b0, sram_dq_oe}, 32'h0);
        check("rst_read_data", read_data, 32'h0);
        check("rst_sram_addr", {14'h0, sram_addr}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Directed vector table
        foreach (vecs[i]) begin
            int lat, we_cnt, oe_cnt, dqoe_cnt, first, last;
            logic done_idle;
            bit is_w;
            is_w = vecs[i].wr;
            run_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, 1'b0,
                       lat, we_cnt, oe_cnt, dqoe_cnt, first, last, done_idle);
            if (is_w) model_mem[int'((vecs[i].addr - 32'd1024) >> 2)] = vecs[i].wdata;
            else model_rd = vecs[i].exp_rdata;
`ifdef SRAM_ACCESS_COUNT_EN
            if (is_w) model_wcnt++; else model_rcnt++;
`endif
            check($sformatf("vec%0d_latency", i), lat, LAT);
            check($sformatf("vec%0d_first", i), first, 1);
            check($sformatf("vec%0d_last", i), last, PH_LAST);
            check($sformatf("vec%0d_we_cycles", i), we_cnt, is_w ? PH_LAST : 0);
            check($sformatf("vec%0d_oe_cycles", i), oe_cnt, is_w ? 0 : PH_LAST);
            check($sformatf("vec%0d_dqoe_cycles", i), dqoe_cnt, is_w ? PH_LAST : 0);
            check($sformatf("vec%0d_done_idle", i), {31'b0, done_idle}, 32'h1);
            check($sformatf("vec%0d_read_data", i), read_data, vecs[i].exp_rdata);
            check($sformatf("vec%0d_sram_lo", i), {16'h0, sram_mem[vecs[i].lo_idx]}, {16'h0, vecs[i].exp_lo});
            check($sformatf("vec%0d_sram_hi", i), {16'h0, sram_mem[vecs[i].lo_idx+1]}, {16'h0, vecs[i].exp_hi});
        end

        // Load held through DONE, then a store in the very next cycle
        access_and_check("b2b_load", 1'b0, 1'b1, 32'd1036, 32'h0, 1'b1);
        access_and_check("b2b_store", 1'b1, 1'b0, 32'd1040, 32'hA5A55A5A, 1'b0);
        access_and_check("b2b_check", 1'b0, 1'b1, 32'd1040, 32'h0, 1'b0);

        // Reset pulsed in the HI phase of a store rewriting the same data
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1024; write_data = 32'hDEADBEEF;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready", {31'b0, ready}, 32'h1);
        check("midrst_we_n", {31'b0, sram_we_n}, 32'h1);
        check("midrst_dq_oe", {31'b0, sram_dq_oe}, 32'h0);
        check("midrst_read_data", read_data, 32'h0);
        @(posedge clk);
        #1;
        check("midrst_edge_ready", {31'b0, ready}, 32'h1);
        check("midrst_edge_we_n", {31'b0, sram_we_n}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        model_rd = 32'h0;
`ifdef SRAM_ACCESS_COUNT_EN
        model_rcnt = 0;
        model_wcnt = 0;
`endif
        access_and_check("post_rst_load", 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);

        // Randomized accesses against the word-level model
        for (int n = 0; n < 40; n++) begin
            int w, op;
            logic [31:0] a, d;
            w  = int'($urandom_range(0, 63));
            op = int'($urandom_range(0, 2));
            a  = 32'd1024 + 32'(w * 4) + 32'($urandom_range(0, 3));
            d  = $urandom;
            access_and_check($sformatf("rand%0d", n), op != 0, op != 1, a, d, 1'b0);
        end

`ifdef SRAM_ACCESS_COUNT_EN
        check("read_count", {16'h0, read_count}, 32'(model_rcnt));
        check("write_count", {16'h0, write_count}, 32'(model_wcnt));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
